muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the 5-stage MIPS pipeline.
- Sits beside the execute-stage ALU and handles MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Drives a stall to the hazard unit while an operation is in flight.
- Width is parametrised, with a per-iteration step of 1 bit, so the same block serves narrow test configurations and the 32-bit core.

Parameters:
- WIDTH, 32, operand/HI/LO width in bits (>=4).
- CNTW, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  request new operation (from execute stage, already qualified by ~flushE).
- op_i  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start_i.
- a_i  in  WIDTH  rs operand (forwarded value); sampled with start_i.
- b_i  in  WIDTH  rt operand (forwarded value); sampled with start_i.
- cancel_i  in  1  abort in-flight operation (exception/flush).
- hi_we_i  in  1  MTHI write.
- lo_we_i  in  1  MTLO write.
- wdata_i  in  WIDTH  MTHI/MTLO data.
- hi_o  out  WIDTH  HI register.
- lo_o  out  WIDTH  LO register.
- busy_o  out  1  operation in flight (registered).
- done_o  out  1  one-cycle pulse when HI/LO receive a result.
- stall_o  out  1  combinational: start_i accepted this cycle OR busy_o; holds F/D/E.
- divzero_o  out  1  one-cycle pulse, coincident with done_o, for DIV/DIVU with b=0.

Behaviour:
- Reset (async, any state): hi_o=0, lo_o=0, busy_o=0, done_o=0, divzero_o=0; FSM returns to IDLE; counter=0.
- FSM states: IDLE, RUN, FIX.

IDLE:
- start_i=1 → latch op and magnitudes. For signed ops, operands are taken as absolute values and result signs are recorded: product/quotient sign = a_msb XOR b_msb; remainder sign = a_msb.
- Counter is loaded with WIDTH; busy_o=1 next cycle; go to RUN.
- In the same cycle, hi_we_i/lo_we_i write wdata_i to HI/LO. A result produced later overwrites them.

RUN:
- One iteration per cycle; counter decrements; after WIDTH iterations go to FIX.
- Multiply: shift-add into a 2*WIDTH accumulator, 1 multiplier bit per cycle.
- Divide: restoring shift-subtract, 1 quotient bit per cycle.

FIX (1 cycle):
- Apply recorded signs (two's complement negate).
- MULT/MULTU: hi=product[2W-1:W], lo=product[W-1:0].
- DIV/DIVU: lo=quotient, hi=remainder. Quotient truncates toward zero.
- Write HI/LO; done_o=1 for this cycle; busy_o=0 next cycle; return to IDLE.

Latency and overflow:
- start_i at edge N → HI/LO valid and done_o high in the cycle after edge N+WIDTH+1, i.e. WIDTH+2 cycles total.
- stall_o is high from the start cycle through the FIX cycle inclusive.
- Signed overflow (-2^(W-1) / -1): lo=2^(W-1) pattern (0x80000000 at W=32), hi=0. No flag.

Divide by zero:
- Takes the same latency; no sign fix.
- Result: hi=a_i as sampled, lo=all ones.
- divzero_o pulses with done_o.

Conflicts while busy:
- start_i, hi_we_i and lo_we_i are ignored while busy_o=1. The pipeline is stalled, so these cannot legally occur.

cancel_i:
- In RUN or FIX: next state IDLE, HI/LO unchanged, no done_o, busy_o=0 next cycle.
- In IDLE: suppresses start_i in the same cycle; MTHI/MTLO writes still occur.

Arithmetic:
- All arithmetic is modulo WIDTH (or 2*WIDTH for the product). No X propagation; the internal datapath is fully reset.

Test Plan:
- MULT a=0xFFFFFFFD(-3), b=5 (W=32) → stall_o high 34 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFF1, done_o single pulse in cycle 34.
- MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. The same operands with MULT → hi=0, lo=1.
- DIV a=-7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=-1 → lo=0x80000000, hi=0. DIVU 100/7 → lo=14, hi=2.
- DIVU a=7, b=0 → divzero_o and done_o pulse together; hi=7, lo=0xFFFFFFFF.
- MTHI 0x1234 then MULT 2*3 with cancel_i asserted 10 cycles after start → busy_o drops next cycle, no done_o, hi=0x1234, lo unchanged. A following MULT completes normally.
- Async rst asserted mid-RUN (between edges) → busy_o, stall_o, hi_o, lo_o go to 0 immediately. After release, a new DIVU 9/3 gives lo=3, hi=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit beside the execute-stage ALU.
// One multiplier/quotient bit per cycle; stalls F/D/E while in flight.
//
// Ports:
//   clk, rst           clock, async active-high reset
//   start_i, op_i      new op request (00 MULT 01 MULTU 10 DIV 11 DIVU)
//   a_i, b_i           rs / rt operands, sampled with start_i
//   cancel_i           abort in-flight op, or suppress start in IDLE
//   hi_we_i, lo_we_i   MTHI / MTLO write enables, wdata_i is the data
//   hi_o, lo_o         architectural HI / LO
//   busy_o             op in flight (registered)
//   done_o             pulse when HI/LO take a result
//   stall_o            start accepted this cycle or busy
//   divzero_o          pulse with done_o for a divide by zero
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNTW  = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cancel_i,
    input  logic             hi_we_i,
    input  logic             lo_we_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             stall_o,
    output logic             divzero_o
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } stateT;

    stateT            state;
    logic [CNTW-1:0]  count;
    logic             isDiv;
    logic             qSign;
    logic             rSign;
    logic             bZero;
    logic [WIDTH-1:0] magB;
    // accHi: partial product high half / partial remainder
    // accLo: multiplier bits / dividend bits shifting into quotient
    logic [WIDTH-1:0] accHi;
    logic [WIDTH-1:0] accLo;

    logic             aNeg;
    logic             bNeg;
    logic [WIDTH-1:0] magAIn;
    logic [WIDTH-1:0] magBIn;

    logic [WIDTH:0]   mulSum;
    logic [WIDTH:0]   divShift;
    logic [WIDTH:0]   divDiff;
    logic             divGe;
    logic [WIDTH-1:0] nextHi;
    logic [WIDTH-1:0] nextLo;

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prodFix;
    logic [WIDTH-1:0]   fixHi;
    logic [WIDTH-1:0]   fixLo;

    // Unsigned ops (op_i[0]=1) never see a negative operand.
    always_comb begin
        aNeg   = ~op_i[0] & a_i[WIDTH-1];
        bNeg   = ~op_i[0] & b_i[WIDTH-1];
        magAIn = aNeg ? -a_i : a_i;
        magBIn = bNeg ? -b_i : b_i;
    end

    always_comb begin
        mulSum   = {1'b0, accHi};
        if (accLo[0]) begin
            mulSum = {1'b0, accHi} + {1'b0, magB};
        end
        divShift = {accHi, accLo[WIDTH-1]};
        divGe    = divShift >= {1'b0, magB};
        divDiff  = divShift - {1'b0, magB};
        if (isDiv) begin
            nextHi = divGe ? divDiff[WIDTH-1:0]
                           : divShift[WIDTH-1:0];
            nextLo = {accLo[WIDTH-2:0], divGe};
        end else begin
            // Carry out of the add shifts down into the high half.
            nextHi = mulSum[WIDTH:1];
            nextLo = {mulSum[0], accLo[WIDTH-1:1]};
        end
    end

    // With a zero divisor the remainder path just shifts the dividend
    // magnitude through, so re-applying the dividend sign returns a_i.
    always_comb begin
        prod    = {accHi, accLo};
        prodFix = qSign ? -prod : prod;
        fixHi   = prodFix[2*WIDTH-1:WIDTH];
        fixLo   = prodFix[WIDTH-1:0];
        unique case (1'b1)
            (isDiv & bZero): begin
                fixHi = rSign ? -accHi : accHi;
                fixLo = '1;
            end
            (isDiv & ~bZero): begin
                fixHi = rSign ? -accHi : accHi;
                fixLo = qSign ? -accLo : accLo;
            end
            (~isDiv): begin
                fixHi = prodFix[2*WIDTH-1:WIDTH];
                fixLo = prodFix[WIDTH-1:0];
            end
        endcase
    end

    assign stall_o = busy_o | (start_i & ~cancel_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            isDiv     <= 1'b0;
            qSign     <= 1'b0;
            rSign     <= 1'b0;
            bZero     <= 1'b0;
            magB      <= '0;
            accHi     <= '0;
            accLo     <= '0;
            hi_o      <= '0;
            lo_o      <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            divzero_o <= 1'b0;
        end else begin
            done_o    <= 1'b0;
            divzero_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (hi_we_i) begin
                        hi_o <= wdata_i;
                    end
                    if (lo_we_i) begin
                        lo_o <= wdata_i;
                    end
                    if (start_i && !cancel_i) begin
                        isDiv  <= op_i[1];
                        qSign  <= aNeg ^ bNeg;
                        rSign  <= aNeg;
                        bZero  <= (b_i == '0);
                        magB   <= magBIn;
                        accHi  <= '0;
                        accLo  <= magAIn;
                        count  <= CNTW'(WIDTH);
                        busy_o <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (cancel_i) begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        accHi <= nextHi;
                        accLo <= nextLo;
                        count <= count - CNTW'(1);
                        if (count == CNTW'(1)) begin
                            state <= FIX;
                        end
                    end
                end
                FIX: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                    if (!cancel_i) begin
                        hi_o      <= fixHi;
                        lo_o      <= fixLo;
                        done_o    <= 1'b1;
                        divzero_o <= isDiv & bZero;
                    end
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
